// File: rtl/ysyx_22041071_rf_wport_arb_pkg.sv
// Shared types and sizes for the register-file write-port arbiter and its scoreboard.
// The MDU starvation guard is enabled by defining YSYX_22041071_STARVE_GUARD_EN.
package ysyx_22041071_rf_wport_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic {
    ARB_PIPE  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ysyx_22041071_rf_wport_arb_if.sv
// WB / MDU / ID / register-file signal bundle around the write-port arbiter.
// master = surrounding pipeline, slave = arbiter.
interface ysyx_22041071_rf_wport_arb_if
  import ysyx_22041071_rf_wport_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_stall;

  logic                  md_valid;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_ready;

  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rt;
  logic                  rs1_busy;
  logic                  rt_busy;
  logic [NUM_REGS-1:0]   sb_busy;

  logic                  rf_w_en;
  logic [REG_ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0]     rf_w_data;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_valid, md_rd, md_data,
    output iss_valid, iss_rd, chk_rs1, chk_rt,
    input  wb_stall, md_ready,
    input  rs1_busy, rt_busy, sb_busy,
    input  rf_w_en, rf_w_addr, rf_w_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_valid, md_rd, md_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rt,
    output wb_stall, md_ready,
    output rs1_busy, rt_busy, sb_busy,
    output rf_w_en, rf_w_addr, rf_w_data
  );

endinterface

// File: rtl/ysyx_22041071_sb_regs.sv
// Outstanding-MDU-destination scoreboard: one set port, one clear port, two read ports.
// Set beats clear on the same register; register 0 is never marked busy.
module ysyx_22041071_sb_regs
  import ysyx_22041071_rf_wport_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] rd_idx_a,
  input  logic [REG_ADDR_W-1:0] rd_idx_b,
  output logic                  busy_a_c,
  output logic                  busy_b_c,
  output logic [NUM_REGS-1:0]   sb_q
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] sb_d;

  // Clear first, then set, so a same-cycle reissue keeps the bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    sb_d    = (sb_q & ~clr_vec) | set_vec;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign busy_a_c = sb_q[rd_idx_a] && (rd_idx_a != REG_ADDR_W'(0));
  assign busy_b_c = sb_q[rd_idx_b] && (rd_idx_b != REG_ADDR_W'(0));

endmodule

// File: rtl/ysyx_22041071_rf_wport_arb.sv
// Register-file write-port arbiter between pipeline WB and MDU writeback, plus MDU scoreboard.
// YSYX_22041071_STARVE_GUARD_EN adds the FORCE state that bounds MDU waiting to STARVE_MAX cycles.
module ysyx_22041071_rf_wport_arb
  import ysyx_22041071_rf_wport_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef YSYX_22041071_STARVE_GUARD_EN
  , parameter int unsigned STARVE_MAX = 4
`endif
) (
  input logic                          clk,
  input logic                          reset,
  ysyx_22041071_rf_wport_arb_if.slave  bus
);

  logic md_ready_c;
  logic wb_stall_c;
  logic md_hs_c;
  logic wb_win_c;

`ifdef YSYX_22041071_STARVE_GUARD_EN
  localparam int unsigned WCNT_W = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_PIPE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Handshake/next-state: FORCE lasts exactly one cycle and gives the MDU priority.
  always_comb begin
    state_d    = ARB_PIPE;
    wcnt_d     = '0;
    md_ready_c = !bus.wb_valid;
    wb_stall_c = 1'b0;
    if (state_q == ARB_FORCE) begin
      md_ready_c = 1'b1;
      wb_stall_c = bus.wb_valid && bus.md_valid;
    end
    if (bus.md_valid && !md_ready_c) wcnt_d = wcnt_q + WCNT_W'(1);
    if ((state_q == ARB_PIPE) && bus.md_valid && !md_ready_c &&
        (wcnt_d == WCNT_W'(STARVE_MAX - 1)))
      state_d = ARB_FORCE;
  end
`else
  // Strict WB priority: the MDU only gets the port on WB bubbles.
  always_comb begin
    md_ready_c = !bus.wb_valid;
    wb_stall_c = 1'b0;
  end
`endif

  // WB takes the port whenever it is requesting and the MDU did not.
  assign md_hs_c  = bus.md_valid && md_ready_c;
  assign wb_win_c = bus.wb_valid && !md_hs_c;

  assign bus.md_ready = md_ready_c;
  assign bus.wb_stall = wb_stall_c;

  logic                  rf_w_en_q;
  logic [REG_ADDR_W-1:0] rf_w_addr_q;
  logic [DATA_W-1:0]     rf_w_data_q;

  // Write-port register; address/data hold when nobody wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_w_en_q   <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
    end else if (md_hs_c) begin
      rf_w_en_q   <= (bus.md_rd != REG_ADDR_W'(0));
      rf_w_addr_q <= bus.md_rd;
      rf_w_data_q <= bus.md_data;
    end else if (wb_win_c) begin
      rf_w_en_q   <= (bus.wb_rd != REG_ADDR_W'(0));
      rf_w_addr_q <= bus.wb_rd;
      rf_w_data_q <= bus.wb_data;
    end else begin
      rf_w_en_q   <= 1'b0;
    end
  end

  assign bus.rf_w_en   = rf_w_en_q;
  assign bus.rf_w_addr = rf_w_addr_q;
  assign bus.rf_w_data = rf_w_data_q;

  logic                rs1_busy_c;
  logic                rt_busy_c;
  logic [NUM_REGS-1:0] sb_q;

  ysyx_22041071_sb_regs u_sb_regs (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.iss_valid && (bus.iss_rd != REG_ADDR_W'(0))),
    .set_idx  (bus.iss_rd),
    .clr_en   (md_hs_c),
    .clr_idx  (bus.md_rd),
    .rd_idx_a (bus.chk_rs1),
    .rd_idx_b (bus.chk_rt),
    .busy_a_c (rs1_busy_c),
    .busy_b_c (rt_busy_c),
    .sb_q     (sb_q)
  );

  assign bus.rs1_busy = rs1_busy_c;
  assign bus.rt_busy  = rt_busy_c;
  assign bus.sb_busy  = sb_q;

endmodule

// File: tb/tb_ysyx_22041071_rf_wport_arb.sv
// Directed bench for the write-port arbiter: per-cycle check against a cycle-level model
// of the arbitration rules, plus hand-computed literal checks at key points.
module tb_ysyx_22041071_rf_wport_arb;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STARVE_MAX = 4;
`ifdef YSYX_22041071_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041071_rf_wport_arb_if #(.DATA_W(DATA_W)) bus ();

  ysyx_22041071_rf_wport_arb #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: busy set, how many consecutive cycles the MDU has been refused, last write.
  bit   [31:0]       m_sb;
  int                m_waited;
  bit                m_en;
  logic [4:0]        m_addr;
  logic [DATA_W-1:0] m_data;

  int n_vec;
  int n_cmp;
  int n_err;
  bit last_rdy;
  bit last_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sb = '0; m_waited = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // One clock: drive after negedge, check combinational outputs, then registered ones after posedge.
  task automatic apply(input bit wbv, input logic [4:0] wbrd, input logic [63:0] wbd,
                       input bit mdv, input logic [4:0] mdrd, input logic [63:0] mdd,
                       input bit issv, input logic [4:0] issrd,
                       input logic [4:0] rs1, input logic [4:0] rt);
    bit forced, rdy, stall, hs;
    bus.wb_valid = wbv;  bus.wb_rd = wbrd;  bus.wb_data = wbd;
    bus.md_valid = mdv;  bus.md_rd = mdrd;  bus.md_data = mdd;
    bus.iss_valid = issv; bus.iss_rd = issrd;
    bus.chk_rs1 = rs1;   bus.chk_rt = rt;
    n_vec++;
    #1;
    forced = GUARD && (m_waited == STARVE_MAX - 1);
    rdy    = forced || !wbv;
    stall  = forced && wbv && mdv;
    hs     = mdv && rdy;
    check("md_ready", bus.md_ready, rdy);
    check("wb_stall", bus.wb_stall, stall);
    check("rs1_busy", bus.rs1_busy, m_sb[rs1] && (rs1 != 0));
    check("rt_busy",  bus.rt_busy,  m_sb[rt]  && (rt  != 0));
    check("sb_busy",  bus.sb_busy,  m_sb);
    last_rdy   = bus.md_ready;
    last_stall = bus.wb_stall;
    @(posedge clk);
    if (hs) begin
      m_en = (mdrd != 0); m_addr = mdrd; m_data = mdd;
    end else if (wbv) begin
      m_en = (wbrd != 0); m_addr = wbrd; m_data = wbd;
    end else begin
      m_en = 1'b0;
    end
    m_waited = (mdv && !rdy) ? m_waited + 1 : 0;
    if (hs) m_sb[mdrd] = 1'b0;
    if (issv && issrd != 0) m_sb[issrd] = 1'b1;
    #1;
    check("rf_w_en", bus.rf_w_en, m_en);
    if (m_en) begin
      check("rf_w_addr", bus.rf_w_addr, m_addr);
      check("rf_w_data", bus.rf_w_data, m_data);
    end
    @(negedge clk);
  endtask

  int first;
  bit any_stall;
  bit md_pend;

  initial begin
    n_vec = 0; n_cmp = 0; n_err = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.chk_rs1 = 0; bus.chk_rt = 0;
    model_reset();
    reset = 1'b0;
    #1;
    check("init_rf_w_en", bus.rf_w_en, 0);
    check("init_rf_w_addr", bus.rf_w_addr, 0);
    check("init_rf_w_data", bus.rf_w_data, 0);
    check("init_sb_busy", bus.sb_busy, 0);
    check("init_md_ready", bus.md_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // WB-only writes, then rd=0 suppression and idle.
    apply(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("wb5_en", bus.rf_w_en, 1);
    check("wb5_addr", bus.rf_w_addr, 5);
    check("wb5_data", bus.rf_w_data, 64'h1234);
    apply(1, 5'd0, 64'hBEEF, 0, 0, 0, 0, 0, 0, 0);
    check("wb0_en", bus.rf_w_en, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Issue x7 and x9 to the MDU; busy visible from the next cycle.
    apply(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd7, 0);
    check("iss7_busy", bus.rs1_busy, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd7);
    check("iss9_busy", bus.rs1_busy, 1);

    // Collision: WB first, MDU on the following idle cycle.
    apply(1, 5'd3, 64'h33, 1, 5'd7, 64'h77, 0, 0, 0, 5'd7);
    check("coll_md_ready", last_rdy, 0);
    check("coll_addr", bus.rf_w_addr, 3);
    apply(0, 0, 0, 1, 5'd7, 64'h77, 0, 0, 0, 5'd7);
    check("md7_addr", bus.rf_w_addr, 7);
    check("md7_data", bus.rf_w_data, 64'h77);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7);
    check("sb7_cleared", bus.rt_busy, 0);

    // Same-cycle reissue and commit of x9: set wins.
    apply(0, 0, 0, 1, 5'd9, 64'h99, 1, 5'd9, 5'd9, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd9, 0);
    check("sb9_kept", bus.rs1_busy, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sb_only9", bus.sb_busy, 32'h200);

    // Starvation: WB requests every cycle while the MDU holds its result.
    first = 0; any_stall = 0; md_pend = 1;
    for (int i = 1; i <= 20; i++) begin
      apply(1, 5'd10, 64'(i), md_pend, 5'd12, 64'hC0DE, 0, 0, 0, 0);
      if (last_stall) any_stall = 1;
      if (md_pend && last_rdy) begin
        first = i;
        md_pend = 0;
        check("starve_md_addr", bus.rf_w_addr, 12);
        check("starve_md_data", bus.rf_w_data, 64'hC0DE);
      end
    end
`ifdef YSYX_22041071_STARVE_GUARD_EN
    check("starve_first_grant", first, 4);
    check("starve_stall_seen", any_stall, 1);
`else
    check("noguard_no_grant", first, 0);
    check("noguard_no_stall", any_stall, 0);
`endif
    apply(0, 0, 0, md_pend, 5'd12, 64'hC0DE, 0, 0, 0, 0);

    // Retire x9, leave only x8 busy, then reset in the middle of a starving stream.
    apply(0, 0, 0, 1, 5'd9, 64'h99, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);
    check("sb_only8", bus.sb_busy, 32'h100);
    for (int i = 0; i < 3; i++) apply(1, 5'd4, 64'h44, 1, 5'd12, 64'hAB, 0, 0, 0, 0);
    bus.wb_valid = 1; bus.md_valid = 1;
    #2;
    reset = 1'b0;
    #1;
    check("rst_sb_busy", bus.sb_busy, 0);
    check("rst_rf_w_en", bus.rf_w_en, 0);
    check("rst_rf_w_addr", bus.rf_w_addr, 0);
    check("rst_rf_w_data", bus.rf_w_data, 0);
    check("rst_md_ready", bus.md_ready, 0);
    check("rst_wb_stall", bus.wb_stall, 0);
    bus.wb_valid = 0; bus.md_valid = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    apply(1, 5'd1, 64'hAA, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_addr", bus.rf_w_addr, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_rf_wport_arb.md
# ysyx_22041071_rf_wport_arb

Register-file write-port arbiter and scoreboard for the ysyx_22041071 pipeline. Shares the single register-file write port between the in-order WB stage and the multi-cycle mul/div unit (MDU) writeback. Tracks destination registers with MDU results still outstanding so ID can stall on them. Sits between WB/MDU and the register file; ID queries its busy bits beside its forwarding logic.

## Interface
- DATA_W, 64, register data width
- STARVE_MAX, 4, consecutive cycles MDU may wait before forced grant (≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline WB write request
- wb_rd  in  5  pipeline WB destination
- wb_data  in  DATA_W  pipeline WB data
- wb_stall  out  1  pipeline WB must hold its request this cycle
- md_valid  in  1  MDU result valid
- md_rd  in  5  MDU destination
- md_data  in  DATA_W  MDU result
- md_ready  out  1  MDU result accepted when md_valid&&md_ready
- iss_valid  in  1  ID dispatches an instruction to the MDU this cycle
- iss_rd  in  5  its destination
- chk_rs1, chk_rt  in  5 each  ID source registers to check
- rs1_busy, rt_busy  out  1 each  source pending in MDU
- sb_busy  out  32  scoreboard vector, bit 0 always 0
- rf_w_en  out  1  register-file write enable
- rf_w_addr  out  5  write address
- rf_w_data  out  DATA_W  write data

## Operation
- FSM states: PIPE (WB priority), FORCE (MDU priority).
- PIPE: md_ready = !wb_valid; wb_stall = 0. Winner is WB if wb_valid, else MDU if md_valid.
- FORCE: md_ready = 1; wb_stall = wb_valid && md_valid; MDU wins if md_valid, else WB.
- Wait counter wcnt: increments when md_valid && !md_ready; clears on MDU handshake or !md_valid. PIPE→FORCE when wcnt reaches STARVE_MAX-1 while still waiting. FORCE→PIPE after one cycle, whether or not the MDU was granted.
- Write port: the winner is registered into rf_w_*. rf_w_en=0 when the winner's rd==0; the handshake still completes. rf_w_en=0 with no winner; addr/data hold their previous values.
- Scoreboard sb[31:0]:
  - iss_valid with iss_rd≠0 sets sb[iss_rd].
  - MDU handshake clears sb[md_rd].
  - Same register set and cleared in one cycle: the set wins.
  - A WB write never touches sb.
- rs1_busy = sb[chk_rs1] && chk_rs1≠0; same rule for rt_busy. Combinational from the registered sb, so the same-cycle clear is not visible until the next cycle.

## Timing
- Reset (async assert, sync release): state=PIPE, wcnt=0, sb=0, rf_w_en=0, rf_w_addr=0, rf_w_data=0. Combinational outputs follow from these and the inputs. Reset mid-transfer drops the request and clears all busy bits.
- Write latency: 1 cycle from the granted request to rf_w_* valid. The register file captures on the following edge.
- md_ready and wb_stall are combinational from state and the valids. There is no path from the data inputs to any handshake output.
- MDU may hold md_valid with stable md_rd/md_data until the handshake; the block never drops an accepted result.
- Worst-case MDU wait is STARVE_MAX cycles (with the guard compiled in).

## Configuration
- YSYX_22041071_STARVE_GUARD_EN defined: FORCE state and wcnt present, behaviour as above.
- Undefined: strict WB priority, no FORCE state, no counter, wb_stall tied 0. ID must insert a WB bubble for MDU completion.

## Structure
- Shared package/define file holds the state encodings (ARB_PIPE, ARB_FORCE), REG_ADDR_W=5, NUM_REGS=32, and the DATA_W default.
- One sub-module: ysyx_22041071_sb_regs (32-bit scoreboard with set/clear ports and two read ports). Arbitration FSM and write-port register live in the top.

## Test plan
- Reset: assert reset low mid-stream with sb=0x0000_0100 → sb_busy=0, rf_w_en=0, state PIPE immediately.
- Only WB: wb_valid, wb_rd=5, wb_data=0x1234 → next cycle rf_w_en=1, addr=5, data=0x1234. Repeat with wb_rd=0 → rf_w_en=0.
- Collision: wb(rd=3) and md(rd=7) both valid, no prior wait → WB written first, md_ready=0. The next cycle with wb idle writes x7; sb[7] clears.
- Starvation (guard on, STARVE_MAX=4): wb_valid held, md_valid held → md_ready=1 and wb_stall=1 on the 4th waiting cycle; x(md_rd) written, then PIPE resumes.
- Scoreboard: iss_rd=9 → rs1_busy=1 for chk_rs1=9 from the next cycle. Same-cycle iss_rd=9 with MDU commit rd=9 → sb[9] stays 1. iss_rd=0 → no bit set.
- Guard off: the same starvation stimulus → md_ready stays 0 and wb_stall stays 0 for 20 cycles.
